// File: rtl/cmp_pkg.sv
// Shared definitions for the stream comparator: FSM encoding and cascade type.
package cmp_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Running relation between the operand prefixes seen so far
    typedef struct packed {
        logic l;
        logic e;
        logic g;
    } cascade_t;

    // A frame that has not yet seen a differing beat compares as equal
    localparam cascade_t CASCADE_RESET = '{l: 1'b0, e: 1'b1, g: 1'b0};

endpackage

// File: rtl/cmp_cell.sv
// One beat of an MSB-first magnitude comparison cascade (purely combinational).
module cmp_cell #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_l,
    input  logic         i_e,
    input  logic         i_g,
    output logic         o_lt,
    output logic         o_eq,
    output logic         o_gt
);

    // A more significant difference already decided the result; otherwise this beat decides
    always_comb begin
        o_lt = i_l;
        o_eq = i_e;
        o_gt = i_g;
        if (i_e) begin
            o_lt = (i_a < i_b);
            o_eq = (i_a == i_b);
            o_gt = (i_a > i_b);
        end
    end

endmodule

// File: rtl/stream_comparator.sv
// Compares two multi-beat operands streamed MSB-first and reports lt/eq/gt per frame.
module stream_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_beat,
    input  logic [W-1:0]     b_beat,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [CNT_W-1:0] beat_count
);

    logic [1:0]       r_state;
    cascade_t         r_cascade;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_consume;
    cascade_t         w_cas_in;
    cascade_t         w_cas_out;
    logic [CNT_W-1:0] w_count_next;

    assign in_ready  = (r_state != ST_DONE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    // First beat of a frame starts from "equal so far"; later beats continue the cascade
    assign w_cas_in = (r_state == ST_IDLE) ? CASCADE_RESET : r_cascade;

    cmp_cell #(
        .W (W)
    ) u_cmp_cell (
        .i_a  (a_beat),
        .i_b  (b_beat),
        .i_l  (w_cas_in.l),
        .i_e  (w_cas_in.e),
        .i_g  (w_cas_in.g),
        .o_lt (w_cas_out.l),
        .o_eq (w_cas_out.e),
        .o_gt (w_cas_out.g)
    );

    // Beat counter: restarts at 1 on the first beat, saturates at all-ones
    always_comb begin
        w_count_next = r_count;
        if (r_state == ST_IDLE) begin
            w_count_next = CNT_W'(1);
        end else if (r_count != {CNT_W{1'b1}}) begin
            w_count_next = r_count + CNT_W'(1);
        end
    end

    // Frame FSM with cascade and count registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cascade <= CASCADE_RESET;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_BUSY: begin
                    if (w_accept) begin
                        r_cascade <= w_cas_out;
                        r_count   <= w_count_next;
                        r_state   <= in_last ? ST_DONE : ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Result consumed: return to a fresh idle view
                    if (w_consume) begin
                        r_state   <= ST_IDLE;
                        r_cascade <= CASCADE_RESET;
                        r_count   <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cascade <= CASCADE_RESET;
                    r_count   <= '0;
                end
            endcase
        end
    end

    assign lt         = r_cascade.l;
    assign eq         = r_cascade.e;
    assign gt         = r_cascade.g;
    assign beat_count = r_count;

endmodule

// File: tb/tb_stream_comparator.sv
// Self-checking bench for stream_comparator: numeric frame model plus directed frames.
module tb_stream_comparator;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a_beat;
    logic [W-1:0]     b_beat;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [CNT_W-1:0] beat_count;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    stream_comparator #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_beat     (a_beat),
        .b_beat     (b_beat),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lt         (lt),
        .eq         (eq),
        .gt         (gt),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each frame is the concatenation of its beats as one wide unsigned number
    int       m_phase = 0;  // 0 idle, 1 receiving, 2 result pending
    bit       m_known = 0;  // running results defined (not after a consume)
    logic [255:0] m_a = '0;
    logic [255:0] m_b = '0;
    int       m_n = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("in_ready", in_ready, m_phase != 2);
                check("out_valid", out_valid, m_phase == 2);
                if (m_known) begin
                    check("lt", lt, m_a < m_b);
                    check("eq", eq, m_a == m_b);
                    check("gt", gt, m_a > m_b);
                    check("beat_count", beat_count, (m_n > SAT) ? SAT : m_n);
                end
            end
            @(posedge clk);
            if (rst) begin
                m_phase = 0;
                m_known = 1;
                m_a = '0;
                m_b = '0;
                m_n = 0;
            end else if (m_phase != 2 && in_valid) begin
                if (m_phase == 0) begin
                    m_a = '0;
                    m_b = '0;
                    m_n = 0;
                end
                m_a = (m_a << W) | 256'(a_beat);
                m_b = (m_b << W) | 256'(b_beat);
                m_n++;
                m_known = 1;
                m_phase = in_last ? 2 : 1;
            end else if (m_phase == 2 && out_ready) begin
                m_phase = 0;
                m_known = 0;
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        in_valid = 1'b1;
        a_beat   = a;
        b_beat   = b;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        int budget = 20;
        while (!out_valid && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("result_timeout", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_consume", out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_beat    = '0;
        b_beat    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1;
        check("rst_eq", eq, 1);
        check("rst_count", beat_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Equal two-beat frame
        send_beat(8'h41, 8'h41, 1'b0);
        send_beat(8'h41, 8'h41, 1'b1);
        check("f1_out_valid", out_valid, 1);
        check("f1_eq", eq, 1);
        check("f1_count", beat_count, 2);
        consume();

        // Upper beat decides; lower beat must not override
        send_beat(8'h40, 8'h0D, 1'b0);
        check("f2_gt_early", gt, 1);
        send_beat(8'h00, 8'hFF, 1'b1);
        check("f2_gt", gt, 1);
        check("f2_lt", lt, 0);
        consume();

        // Single-beat frame goes straight to the result
        send_beat(8'h1F, 8'h80, 1'b1);
        check("f3_out_valid", out_valid, 1);
        check("f3_lt", lt, 1);
        check("f3_count", beat_count, 1);

        // Hold the result with pressure on the input side
        in_valid = 1'b1;
        a_beat   = 8'hFF;
        b_beat   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_lt", lt, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_count", beat_count, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("hold_released", out_valid, 0);
        check("hold_released_ready", in_ready, 1);

        // Gap cycles inside a frame leave state unchanged
        send_beat(8'h10, 8'h10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("gap_count", beat_count, 1);
        send_beat(8'h05, 8'h06, 1'b1);
        check("gap_lt", lt, 1);
        consume();

        // Counter saturation over 17 beats
        for (int i = 0; i < 17; i++) begin
            send_beat(W'(i), W'(i), i == 16);
        end
        check("sat_count", beat_count, SAT);
        check("sat_eq", eq, 1);
        consume();

        // Reset mid-frame, colliding with a beat
        send_beat(8'h01, 8'h00, 1'b0);
        send_beat(8'h02, 8'h02, 1'b0);
        send_beat(8'h03, 8'h03, 1'b0);
        check("pre_rst_count", beat_count, 3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("mid_rst_eq", eq, 1);
        check("mid_rst_count", beat_count, 0);
        check("mid_rst_out_valid", out_valid, 0);

        // Reset while a result is pending discards it
        send_beat(8'h90, 8'h20, 1'b1);
        check("f_pend_gt", gt, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_eq", eq, 1);

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
